cms_trace_stream_reader: RTL and testbench

AXI-Stream slave at the consumer end of the continuous_monitoring_system trace stream. It accepts wide trace items of AXI_DATA_WIDTH bits and decodes the pc, instr and clk_counter_delta fields as a side-band pulse. It then serialises each item into OUT_WIDTH-bit words on a narrow AXI-Stream master. It also counts items, counts packets, and checks tlast spacing against the configured tlast_interval.

---
 rtl/continuous_monitoring_system_pkg.sv | 33 +++
 rtl/cms_wide_to_narrow_serializer.sv | 83 ++++++++
 rtl/cms_trace_stream_reader.sv | 99 +++++++++
 tb/tb_cms_trace_stream_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared definitions for the continuous monitoring system trace path.
// The trace writer and this reader both import the field location constants,
// so the wide trace item layout is defined once and cannot drift.
package continuous_monitoring_system_pkg;

    localparam int XLEN                                = 64;
    localparam int NO_OF_PERFORMANCE_EVENTS            = 29;
    localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 7;
    localparam int CLK_COUNTER_WIDTH                   = 64;
    localparam int CLK_COUNTER_DELTA_WIDTH             = CLK_COUNTER_WIDTH;
    localparam int INSTR_WIDTH                         = 32;

    localparam int DEFAULT_AXI_DATA_WIDTH = 1024;
    localparam int DEFAULT_OUT_WIDTH      = 64;

    // Item layout, LSB upwards: performance event counters, clock counter
    // delta, pc, instr. Any remaining upper bits are padding.
    localparam int CLK_COUNTER_DELTA_LOCATION =
        NO_OF_PERFORMANCE_EVENTS * PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;
    localparam int PC_LOCATION    = CLK_COUNTER_DELTA_LOCATION + CLK_COUNTER_WIDTH;
    localparam int INSTR_LOCATION = PC_LOCATION + XLEN;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } reader_state_t;

    // Width of a counter that indexes n words; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cms_wide_to_narrow_serializer.sv
// Holds one wide item and emits it LSB-first as OUT_WIDTH-bit words.
// The input is ready again in the same cycle the last word is taken, so
// consecutive items stream without a bubble.
module cms_wide_to_narrow_serializer #(
    parameter int AXI_DATA_WIDTH = continuous_monitoring_system_pkg::DEFAULT_AXI_DATA_WIDTH,
    parameter int OUT_WIDTH      = continuous_monitoring_system_pkg::DEFAULT_OUT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AXI_DATA_WIDTH-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_last
);
    import continuous_monitoring_system_pkg::*;

    localparam int BEATS  = AXI_DATA_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = index_width(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    reader_state_t                    state, state_next;
    logic [BEATS-1:0][OUT_WIDTH-1:0]  hold;
    logic                             hold_last;
    logic [BEAT_W-1:0]                beat;
    logic                             in_fire;
    logic                             out_fire;
    logic                             last_beat_taken;

    assign in_fire         = in_valid && in_ready;
    assign out_fire        = out_valid && out_ready;
    assign last_beat_taken = (state == SEND) && (beat == LAST_BEAT) && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers update with <= so every flop samples pre-edge values;
        // a blocking = here would let later statements see the new value.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: accept from IDLE, leave SEND after the last word unless
    // a new item is accepted in that same cycle.
    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch.
        state_next = state;
        unique case (state)
            IDLE: if (in_fire)         state_next = SEND;
            SEND: if (last_beat_taken) state_next = in_fire ? SEND : IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Outputs: ready when empty or when the last word is leaving; the current
    // word is selected from the hold register by the beat counter.
    always_comb begin
        in_ready  = !rst && ((state == IDLE) || last_beat_taken);
        out_valid = (state == SEND);
        out_data  = hold[beat];
        out_last  = (state == SEND) && (beat == LAST_BEAT) && hold_last;
    end

    // Hold register and beat counter: load on accept, step on each word taken.
    always_ff @(posedge clk) begin
        // NOTE: the hold register is cleared on reset so no stale item data is
        // visible on out_data afterwards; this costs a reset net on every bit.
        if (rst) begin
            hold      <= '0;
            hold_last <= 1'b0;
            beat      <= '0;
        end else if (in_fire) begin
            hold      <= in_data;
            hold_last <= in_last;
            beat      <= '0;
        end else if (out_fire) begin
            beat      <= beat + BEAT_W'(1);
        end
    end

endmodule

// File: rtl/cms_trace_stream_reader.sv
// Consumer end of the monitoring trace stream: decodes each accepted item,
// serialises it onto a narrow stream and keeps item/packet statistics with a
// sticky check on the spacing of tlast.
module cms_trace_stream_reader #(
    parameter int XLEN           = continuous_monitoring_system_pkg::XLEN,
    parameter int AXI_DATA_WIDTH = continuous_monitoring_system_pkg::DEFAULT_AXI_DATA_WIDTH,
    parameter int OUT_WIDTH      = continuous_monitoring_system_pkg::DEFAULT_OUT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    output logic                      M_AXIS_tvalid,
    input  logic                      M_AXIS_tready,
    output logic [OUT_WIDTH-1:0]      M_AXIS_tdata,
    output logic                      M_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    input  logic                      clear_counters,
    output logic                      dec_valid,
    output logic [XLEN-1:0]           dec_pc,
    output logic [31:0]               dec_instr,
    output logic [continuous_monitoring_system_pkg::CLK_COUNTER_DELTA_WIDTH-1:0] dec_clk_counter_delta,
    output logic [31:0]               item_count,
    output logic [31:0]               packet_count,
    output logic                      interval_err
);
    import continuous_monitoring_system_pkg::*;

    logic        wide_fire;
    logic [31:0] since_last;
    logic [31:0] since_base;
    logic [31:0] since_next;
    logic [31:0] item_base;
    logic [31:0] packet_base;
    logic        err_base;
    logic        err_set;

    assign wide_fire = S_AXIS_tvalid && S_AXIS_tready;

    cms_wide_to_narrow_serializer #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .OUT_WIDTH      (OUT_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (S_AXIS_tvalid),
        .in_ready  (S_AXIS_tready),
        .in_data   (S_AXIS_tdata),
        .in_last   (S_AXIS_tlast),
        .out_valid (M_AXIS_tvalid),
        .out_ready (M_AXIS_tready),
        .out_data  (M_AXIS_tdata),
        .out_last  (M_AXIS_tlast)
    );

    // Statistics next values: a clear zeroes the base, then an item accepted in
    // the same cycle is still counted and checked against that zero base.
    always_comb begin
        item_base   = clear_counters ? 32'd0 : item_count;
        packet_base = clear_counters ? 32'd0 : packet_count;
        since_base  = clear_counters ? 32'd0 : since_last;
        err_base    = clear_counters ? 1'b0  : interval_err;
        since_next  = since_base + 32'd1;
        err_set     = 1'b0;
        if (wide_fire && (tlast_interval != 32'd0)) begin
            err_set = S_AXIS_tlast ? (since_next != tlast_interval)
                                   : (since_next >  tlast_interval);
        end
    end

    // Decoded fields, counters and the sticky interval error.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid             <= 1'b0;
            dec_pc                <= '0;
            dec_instr             <= '0;
            dec_clk_counter_delta <= '0;
            item_count            <= '0;
            packet_count          <= '0;
            since_last            <= '0;
            interval_err          <= 1'b0;
        end else begin
            dec_valid <= wide_fire;
            if (wide_fire) begin
                dec_pc                <= S_AXIS_tdata[PC_LOCATION +: XLEN];
                dec_instr             <= S_AXIS_tdata[INSTR_LOCATION +: INSTR_WIDTH];
                dec_clk_counter_delta <= S_AXIS_tdata[CLK_COUNTER_DELTA_LOCATION +: CLK_COUNTER_DELTA_WIDTH];
            end
            item_count   <= item_base + {31'd0, wide_fire};
            packet_count <= packet_base + {31'd0, wide_fire && S_AXIS_tlast};
            if (wide_fire) since_last <= S_AXIS_tlast ? 32'd0 : since_next;
            else           since_last <= since_base;
            interval_err <= err_base || err_set;
        end
    end

endmodule

// File: tb/tb_cms_trace_stream_reader.sv
// Directed bench for cms_trace_stream_reader with the default 1024 -> 64 widths.
module tb_cms_trace_stream_reader;
    import continuous_monitoring_system_pkg::*;

    localparam int W     = 1024;
    localparam int OW    = 64;
    localparam int BEATS = W / OW;

    logic          clk = 1'b0;
    logic          rst;
    logic          S_AXIS_tvalid;
    logic          S_AXIS_tready;
    logic [W-1:0]  S_AXIS_tdata;
    logic          S_AXIS_tlast;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready;
    logic [OW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tlast;
    logic [31:0]   tlast_interval;
    logic          clear_counters;
    logic          dec_valid;
    logic [XLEN-1:0] dec_pc;
    logic [31:0]   dec_instr;
    logic [CLK_COUNTER_DELTA_WIDTH-1:0] dec_clk_counter_delta;
    logic [31:0]   item_count;
    logic [31:0]   packet_count;
    logic          interval_err;

    int nvec = 0;
    int nerr = 0;
    int exp_items = 0;
    int exp_packets = 0;

    always #5 clk = ~clk;

    cms_trace_stream_reader dut (
        .clk                   (clk),
        .rst                   (rst),
        .S_AXIS_tvalid         (S_AXIS_tvalid),
        .S_AXIS_tready         (S_AXIS_tready),
        .S_AXIS_tdata          (S_AXIS_tdata),
        .S_AXIS_tlast          (S_AXIS_tlast),
        .M_AXIS_tvalid         (M_AXIS_tvalid),
        .M_AXIS_tready         (M_AXIS_tready),
        .M_AXIS_tdata          (M_AXIS_tdata),
        .M_AXIS_tlast          (M_AXIS_tlast),
        .tlast_interval        (tlast_interval),
        .clear_counters        (clear_counters),
        .dec_valid             (dec_valid),
        .dec_pc                (dec_pc),
        .dec_instr             (dec_instr),
        .dec_clk_counter_delta (dec_clk_counter_delta),
        .item_count            (item_count),
        .packet_count          (packet_count),
        .interval_err          (interval_err)
    );

    // Item whose 64-bit word k holds base + k.
    function automatic logic [W-1:0] make_item(input logic [63:0] base);
        logic [W-1:0] v;
        for (int k = 0; k < BEATS; k++) v[k*OW +: OW] = base + 64'(k);
        return v;
    endfunction

    task automatic check_counts(input string tag, input logic exp_err);
        nvec++;
        if (item_count !== 32'(exp_items)) begin
            nerr++; $display("FAIL %s item_count: got %0d want %0d", tag, item_count, exp_items);
        end
        nvec++;
        if (packet_count !== 32'(exp_packets)) begin
            nerr++; $display("FAIL %s packet_count: got %0d want %0d", tag, packet_count, exp_packets);
        end
        nvec++;
        if (interval_err !== exp_err) begin
            nerr++; $display("FAIL %s interval_err: got %b want %b", tag, interval_err, exp_err);
        end
    endtask

    // Offer one item, wait for its handshake and for all words to drain.
    task automatic send_item(input logic [W-1:0] data, input logic last, input logic clr);
        int n;
        @(negedge clk);
        S_AXIS_tvalid  = 1'b1;
        S_AXIS_tdata   = data;
        S_AXIS_tlast   = last;
        clear_counters = clr;
        #1;
        n = 0;
        while (!S_AXIS_tready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        nvec++;
        if (n >= 40) begin
            nerr++; $display("FAIL send_item accept timeout: got tready=0 want 1");
        end
        @(negedge clk);
        S_AXIS_tvalid  = 1'b0;
        clear_counters = 1'b0;
        exp_items++;
        if (last) exp_packets++;
        n = 0;
        while (M_AXIS_tvalid && n < 40) begin
            @(negedge clk); n++;
        end
        nvec++;
        if (n >= 40) begin
            nerr++; $display("FAIL send_item drain timeout: got tvalid=1 want 0");
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_counters = 1'b1;
        @(negedge clk);
        clear_counters = 1'b0;
        exp_items = 0;
        exp_packets = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        nvec++;
        if (S_AXIS_tready !== 1'b0) begin
            nerr++; $display("FAIL reset tready_in_reset: got %b want 0", S_AXIS_tready);
        end
        rst = 1'b0;
        #1;
        nvec++;
        if (S_AXIS_tready !== 1'b1) begin
            nerr++; $display("FAIL reset tready_idle: got %b want 1", S_AXIS_tready);
        end
        nvec++;
        if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tlast !== 1'b0 || M_AXIS_tdata !== 64'd0) begin
            nerr++; $display("FAIL reset m_axis: got v=%b l=%b d=%h want 0 0 0", M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata);
        end
        nvec++;
        if (dec_valid !== 1'b0 || dec_pc !== '0) begin
            nerr++; $display("FAIL reset dec: got v=%b pc=%h want 0 0", dec_valid, dec_pc);
        end
        check_counts("reset", 1'b0);
    endtask

    task automatic test_single_item();
        logic [W-1:0] item;
        item = make_item(64'd1);
        @(negedge clk);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = item;
        S_AXIS_tlast  = 1'b0;
        @(negedge clk);
        S_AXIS_tvalid = 1'b0;
        exp_items++;
        nvec++;
        if (dec_pc !== item[PC_LOCATION +: XLEN] || dec_instr !== item[INSTR_LOCATION +: 32] ||
            dec_clk_counter_delta !== item[CLK_COUNTER_DELTA_LOCATION +: CLK_COUNTER_DELTA_WIDTH]) begin
            nerr++; $display("FAIL single decode: got pc=%h instr=%h delta=%h want %h %h %h",
                dec_pc, dec_instr, dec_clk_counter_delta, item[PC_LOCATION +: XLEN],
                item[INSTR_LOCATION +: 32], item[CLK_COUNTER_DELTA_LOCATION +: CLK_COUNTER_DELTA_WIDTH]);
        end
        for (int k = 0; k < BEATS; k++) begin
            nvec++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 64'(k + 1) || M_AXIS_tlast !== 1'b0) begin
                nerr++; $display("FAIL single word%0d: got v=%b d=%h l=%b want 1 %h 0",
                    k, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast, k + 1);
            end
            nvec++;
            if (dec_valid !== (k == 0)) begin
                nerr++; $display("FAIL single dec_valid%0d: got %b want %b", k, dec_valid, k == 0);
            end
            @(negedge clk);
        end
        nvec++;
        if (M_AXIS_tvalid !== 1'b0) begin
            nerr++; $display("FAIL single idle_after: got tvalid=%b want 0", M_AXIS_tvalid);
        end
        check_counts("single", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic [63:0]  exp_word;
        a = make_item(64'h100);
        b = make_item(64'h200);
        @(negedge clk);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = a;
        S_AXIS_tlast  = 1'b0;
        @(negedge clk);
        S_AXIS_tdata  = b;
        S_AXIS_tlast  = 1'b1;
        for (int i = 0; i < 2 * BEATS; i++) begin
            if (i == BEATS) S_AXIS_tvalid = 1'b0;
            exp_word = (i < BEATS) ? 64'h100 + 64'(i) : 64'h200 + 64'(i - BEATS);
            nvec++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== exp_word || M_AXIS_tlast !== (i == 2 * BEATS - 1)) begin
                nerr++; $display("FAIL b2b word%0d: got v=%b d=%h l=%b want 1 %h %b",
                    i, M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast, exp_word, i == 2 * BEATS - 1);
            end
            nvec++;
            if (S_AXIS_tready !== (i == BEATS - 1 || i == 2 * BEATS - 1)) begin
                nerr++; $display("FAIL b2b tready%0d: got %b want %b", i, S_AXIS_tready, i == BEATS - 1 || i == 2 * BEATS - 1);
            end
            @(negedge clk);
        end
        exp_items += 2;
        exp_packets += 1;
        nvec++;
        if (M_AXIS_tvalid !== 1'b0) begin
            nerr++; $display("FAIL b2b idle_after: got tvalid=%b want 0", M_AXIS_tvalid);
        end
        check_counts("b2b", 1'b0);
    endtask

    task automatic test_stall();
        logic       pat [4];
        int         idx;
        int         c;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = make_item(64'h300);
        S_AXIS_tlast  = 1'b0;
        @(negedge clk);
        S_AXIS_tvalid = 1'b0;
        exp_items++;
        idx = 0;
        c = 0;
        while (idx < BEATS && c < 200) begin
            M_AXIS_tready = pat[c % 4];
            #1;
            nvec++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 64'h300 + 64'(idx)) begin
                nerr++; $display("FAIL stall cyc%0d: got v=%b d=%h want 1 %h", c, M_AXIS_tvalid, M_AXIS_tdata, 64'h300 + 64'(idx));
            end
            nvec++;
            if (S_AXIS_tready !== (idx == BEATS - 1 && M_AXIS_tready)) begin
                nerr++; $display("FAIL stall tready cyc%0d: got %b want %b", c, S_AXIS_tready, idx == BEATS - 1 && M_AXIS_tready);
            end
            if (M_AXIS_tready) idx++;
            c++;
            @(negedge clk);
        end
        M_AXIS_tready = 1'b1;
        nvec++;
        if (M_AXIS_tvalid !== 1'b0 || c >= 200) begin
            nerr++; $display("FAIL stall drain: got tvalid=%b cycles=%0d want 0 <200", M_AXIS_tvalid, c);
        end
        check_counts("stall", 1'b0);
    endtask

    task automatic test_interval();
        pulse_clear();
        check_counts("clear0", 1'b0);
        tlast_interval = 32'd3;
        send_item(make_item(64'h400), 1'b0, 1'b0);
        check_counts("int3_item1", 1'b0);
        send_item(make_item(64'h410), 1'b1, 1'b0);
        check_counts("int3_short", 1'b1);
        pulse_clear();
        check_counts("clear1", 1'b0);
        tlast_interval = 32'd2;
        send_item(make_item(64'h420), 1'b0, 1'b0);
        send_item(make_item(64'h430), 1'b0, 1'b0);
        check_counts("int2_ok", 1'b0);
        send_item(make_item(64'h440), 1'b0, 1'b0);
        check_counts("int2_overrun", 1'b1);
        tlast_interval = 32'd0;
        exp_items = 0;
        exp_packets = 0;
        send_item(make_item(64'h450), 1'b1, 1'b1);
        check_counts("clear_with_item", 1'b0);
    endtask

    task automatic test_interval_disabled();
        logic last;
        tlast_interval = 32'd0;
        for (int i = 0; i < 6; i++) begin
            last = 1'($urandom_range(0, 1));
            send_item(make_item(64'h500 + 64'(i * 16)), last, 1'b0);
            check_counts("disabled", 1'b0);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = make_item(64'h600);
        S_AXIS_tlast  = 1'b1;
        @(negedge clk);
        S_AXIS_tvalid = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        nvec++;
        if (M_AXIS_tdata !== 64'h605) begin
            nerr++; $display("FAIL midrst beat5: got %h want %h", M_AXIS_tdata, 64'h605);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_items = 0;
        exp_packets = 0;
        #1;
        nvec++;
        if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 64'd0 || S_AXIS_tready !== 1'b1) begin
            nerr++; $display("FAIL midrst idle: got v=%b d=%h rdy=%b want 0 0 1", M_AXIS_tvalid, M_AXIS_tdata, S_AXIS_tready);
        end
        check_counts("midrst", 1'b0);
        @(negedge clk);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = make_item(64'h700);
        S_AXIS_tlast  = 1'b0;
        @(negedge clk);
        S_AXIS_tvalid = 1'b0;
        exp_items++;
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 64'h700 + 64'(k)) begin
                nerr++; $display("FAIL midrst fresh word%0d: got v=%b d=%h want 1 %h", k, M_AXIS_tvalid, M_AXIS_tdata, 64'h700 + 64'(k));
            end
            @(negedge clk);
        end
        for (int k = 3; k < BEATS; k++) @(negedge clk);
        check_counts("fresh", 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        S_AXIS_tvalid  = 1'b0;
        S_AXIS_tdata   = '0;
        S_AXIS_tlast   = 1'b0;
        M_AXIS_tready  = 1'b1;
        tlast_interval = 32'd0;
        clear_counters = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_item();
        test_back_to_back();
        test_stall();
        test_interval();
        test_interval_disabled();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
